// File: rtl/reg_pkg.sv
// Shared rename-recovery types: recovery sequencer states, default sizing and
// physical/architectural register index types.
package reg_pkg;

    localparam int NUM_PHYS_REGS       = 64;
    localparam int NUM_ARCH_REGS       = 32;
    localparam int RECOVERY_COPY_WIDTH = 4;

    localparam int PREG_W = $clog2(NUM_PHYS_REGS);
    localparam int AREG_W = $clog2(NUM_ARCH_REGS + 1);

    typedef logic [PREG_W-1:0] preg_idx_t;
    typedef logic [AREG_W-1:0] areg_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        COPY,
        REBUILD,
        DONE
    } rat_recovery_state_e;

endpackage

// File: rtl/rat_recovery_free_scan.sv
// Combinational free-list rebuild lanes: lane k offers physical register p+k
// to the FRL when no committed mapping points at it.
module rat_recovery_free_scan #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int COPY_WIDTH    = 4,
    parameter int PCNT_W        = $clog2(NUM_PHYS_REGS + 1),
    parameter int PW            = $clog2(NUM_PHYS_REGS)
) (
    input  logic                             scan_en,
    input  logic [PCNT_W-1:0]                pcnt,
    input  logic [NUM_PHYS_REGS-1:0]         mapped,
    output logic [COPY_WIDTH-1:0]            push_valid,
    output logic [COPY_WIDTH-1:0][PW-1:0]    push_preg
);

    always_comb begin
        push_valid = '0;
        push_preg  = '0;
        if (scan_en) begin
            for (int k = 0; k < COPY_WIDTH; k++) begin
                // Lanes past the end of the register file belong to a partial final chunk.
                if (int'(pcnt) + k < NUM_PHYS_REGS) begin
                    if (!mapped[PW'(int'(pcnt) + k)]) begin
                        push_valid[k] = 1'b1;
                        push_preg[k]  = PW'(int'(pcnt) + k);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rat_recovery_ctrl.sv
// Flush recovery sequencer: drain commits, copy RRAT (GPRs + NZCV) into the RAT,
// then rebuild the FRL from unmapped pregs. Optional stats: RAT_RECOVERY_STATS_EN.
module rat_recovery_ctrl #(
    parameter int NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
    parameter int NUM_ARCH_REGS = reg_pkg::NUM_ARCH_REGS,
    parameter int COPY_WIDTH    = reg_pkg::RECOVERY_COPY_WIDTH,
    parameter int PW            = $clog2(NUM_PHYS_REGS),
    parameter int AW            = $clog2(NUM_ARCH_REGS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_req,
    input  logic                          commit_busy,
    output logic                          stall_rename,
    output logic [COPY_WIDTH-1:0][AW-1:0] rrat_rd_idx,
    input  logic [COPY_WIDTH-1:0][PW-1:0] rrat_rd_data,
    output logic [COPY_WIDTH-1:0]         rat_wr_valid,
    output logic [COPY_WIDTH-1:0][AW-1:0] rat_wr_idx,
    output logic [COPY_WIDTH-1:0][PW-1:0] rat_wr_preg,
    output logic                          frl_clear,
    output logic [COPY_WIDTH-1:0]         frl_push_valid,
    output logic [COPY_WIDTH-1:0][PW-1:0] frl_push_preg,
`ifdef RAT_RECOVERY_STATS_EN
    output logic [15:0]                   recovery_count,
    output logic [15:0]                   last_recovery_cycles,
`endif
    output logic                          recovery_done
);

    import reg_pkg::*;

    localparam int ACNT_W = $clog2(NUM_ARCH_REGS + 2);
    localparam int PCNT_W = $clog2(NUM_PHYS_REGS + 1);

    rat_recovery_state_e        state_q, state_d;
    logic [ACNT_W-1:0]          acnt_q, acnt_d;
    logic [PCNT_W-1:0]          pcnt_q, pcnt_d;
    logic [NUM_PHYS_REGS-1:0]   mapped_q, mapped_d;
    logic                       scan_en;

    assign stall_rename = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        acnt_d        = acnt_q;
        pcnt_d        = pcnt_q;
        mapped_d      = mapped_q;
        rrat_rd_idx   = '0;
        rat_wr_valid  = '0;
        rat_wr_idx    = '0;
        rat_wr_preg   = '0;
        frl_clear     = 1'b0;
        recovery_done = 1'b0;
        scan_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d  = DRAIN;
                    acnt_d   = '0;
                    pcnt_d   = '0;
                    mapped_d = '0;
                end
            end
            DRAIN: begin
                if (!commit_busy) state_d = COPY;
            end
            COPY: begin
                frl_clear = (acnt_q == '0);
                for (int k = 0; k < COPY_WIDTH; k++) begin
                    if (int'(acnt_q) + k <= NUM_ARCH_REGS) begin
                        rrat_rd_idx[k]  = AW'(int'(acnt_q) + k);
                        rat_wr_valid[k] = 1'b1;
                        rat_wr_idx[k]   = AW'(int'(acnt_q) + k);
                        rat_wr_preg[k]  = rrat_rd_data[k];
                        // Duplicate mappings simply re-set the same bit.
                        mapped_d[rrat_rd_data[k]] = 1'b1;
                    end
                end
                if (int'(acnt_q) + COPY_WIDTH > NUM_ARCH_REGS) state_d = REBUILD;
                else acnt_d = acnt_q + ACNT_W'(COPY_WIDTH);
            end
            REBUILD: begin
                scan_en = 1'b1;
                if (int'(pcnt_q) + COPY_WIDTH >= NUM_PHYS_REGS) state_d = DONE;
                else pcnt_d = pcnt_q + PCNT_W'(COPY_WIDTH);
            end
            DONE: begin
                recovery_done = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acnt_q   <= '0;
            pcnt_q   <= '0;
            mapped_q <= '0;
        end else begin
            state_q  <= state_d;
            acnt_q   <= acnt_d;
            pcnt_q   <= pcnt_d;
            mapped_q <= mapped_d;
        end
    end

    rat_recovery_free_scan #(
        .NUM_PHYS_REGS (NUM_PHYS_REGS),
        .COPY_WIDTH    (COPY_WIDTH),
        .PCNT_W        (PCNT_W),
        .PW            (PW)
    ) u_free_scan (
        .scan_en    (scan_en),
        .pcnt       (pcnt_q),
        .mapped     (mapped_q),
        .push_valid (frl_push_valid),
        .push_preg  (frl_push_preg)
    );

`ifdef RAT_RECOVERY_STATS_EN
    logic [15:0] rec_cnt_q, rec_cnt_d;
    logic [15:0] cyc_cnt_q, cyc_cnt_d;
    logic [15:0] last_cyc_q, last_cyc_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // cyc_cnt_q holds the 1-based cycle number of the current recovery cycle.
    always_comb begin
        rec_cnt_d  = rec_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        last_cyc_d = last_cyc_q;
        if (state_q == IDLE) begin
            if (flush_req) cyc_cnt_d = 16'd1;
        end else begin
            cyc_cnt_d = sat_inc16(cyc_cnt_q);
        end
        if (state_q == DONE) begin
            rec_cnt_d  = sat_inc16(rec_cnt_q);
            last_cyc_d = cyc_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_cnt_q  <= '0;
            cyc_cnt_q  <= '0;
            last_cyc_q <= '0;
        end else begin
            rec_cnt_q  <= rec_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            last_cyc_q <= last_cyc_d;
        end
    end

    assign recovery_count       = rec_cnt_q;
    assign last_recovery_cycles = last_cyc_q;
`endif

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Scoreboard bench for rat_recovery_ctrl: table of recovery scenarios plus
// hand-written reset and re-flush sequences.
`timescale 1ns/1ps
module tb_rat_recovery_ctrl;

    localparam int NP = 64;
    localparam int NA = 32;
    localparam int CW = 4;
    localparam int PW = 6;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst, flush_req, commit_busy;
    logic stall_rename, frl_clear, recovery_done;
    logic [CW-1:0][AW-1:0] rrat_rd_idx, rat_wr_idx;
    logic [CW-1:0][PW-1:0] rrat_rd_data, rat_wr_preg, frl_push_preg;
    logic [CW-1:0]         rat_wr_valid, frl_push_valid;
`ifdef RAT_RECOVERY_STATS_EN
    logic [15:0] recovery_count, last_recovery_cycles;
`endif

    always #5 clk = ~clk;

    rat_recovery_ctrl #(
        .NUM_PHYS_REGS(NP), .NUM_ARCH_REGS(NA), .COPY_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .commit_busy(commit_busy),
        .stall_rename(stall_rename), .rrat_rd_idx(rrat_rd_idx), .rrat_rd_data(rrat_rd_data),
        .rat_wr_valid(rat_wr_valid), .rat_wr_idx(rat_wr_idx), .rat_wr_preg(rat_wr_preg),
        .frl_clear(frl_clear), .frl_push_valid(frl_push_valid), .frl_push_preg(frl_push_preg),
`ifdef RAT_RECOVERY_STATS_EN
        .recovery_count(recovery_count), .last_recovery_cycles(last_recovery_cycles),
`endif
        .recovery_done(recovery_done)
    );

    // Committed-mapping model answering the RRAT read port combinationally.
    logic [PW-1:0] rrat [0:NA];
    always_comb begin
        rrat_rd_data = '0;
        for (int k = 0; k < CW; k++)
            if (int'(rrat_rd_idx[k]) <= NA) rrat_rd_data[k] = rrat[rrat_rd_idx[k]];
    end

    typedef struct { int idx; int preg; } ratw_t;
    typedef struct { int mode; int busy; int extra_at; int lat; int pushes; } vec_t;

    ratw_t exp_rat[$];
    int    exp_frl[$];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_wr_cyc, clear_count, clear_cyc, done_count, done_cyc, push_count;
    int rec_total = 0;
    logic [CW-1:0] last_mask;

    function automatic void check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void set_rrat(input int mode);
        for (int i = 0; i <= NA; i++) begin
            if (mode == 2) rrat[i] = PW'(63 - i);
            else           rrat[i] = PW'(i);
        end
        if (mode == 1) begin
            rrat[3] = PW'(40);
            rrat[7] = PW'(40);
        end
    endfunction

    function automatic void build_expect();
        logic [NP-1:0] m;
        ratw_t w;
        m = '0;
        exp_rat.delete();
        exp_frl.delete();
        for (int i = 0; i <= NA; i++) begin
            w.idx  = i;
            w.preg = int'(rrat[i]);
            exp_rat.push_back(w);
            m[rrat[i]] = 1'b1;
        end
        for (int p = 0; p < NP; p++)
            if (!m[p]) exp_frl.push_back(p);
    endfunction

    function automatic int outputs_nonzero();
        logic any;
        any = |{stall_rename, rrat_rd_idx, rat_wr_valid, rat_wr_idx, rat_wr_preg,
                frl_clear, frl_push_valid, frl_push_preg, recovery_done};
`ifdef RAT_RECOVERY_STATS_EN
        any = any | (|{recovery_count, last_recovery_cycles});
`endif
        return int'(any);
    endfunction

    function automatic void clear_marks();
        first_wr_cyc = -1;
        clear_count  = 0;
        clear_cyc    = -1;
        done_count   = 0;
        done_cyc     = -1;
        push_count   = 0;
        last_mask    = '0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop the scoreboard for every RAT write and FRL push.
    always @(negedge clk) begin
        ratw_t e;
        int    p;
        if (rat_wr_valid != '0 && first_wr_cyc < 0) first_wr_cyc = cyc;
        for (int k = 0; k < CW; k++) begin
            if (rat_wr_valid[k]) begin
                if (int'(rat_wr_idx[k]) == NA) last_mask = rat_wr_valid;
                if (exp_rat.size() == 0) begin
                    check("rat_write_unexpected", int'(rat_wr_idx[k]), -1);
                end else begin
                    e = exp_rat.pop_front();
                    check("rat_write", int'(rat_wr_idx[k]) * 256 + int'(rat_wr_preg[k]),
                          e.idx * 256 + e.preg);
                end
            end
            if (frl_push_valid[k]) begin
                push_count++;
                if (exp_frl.size() == 0) begin
                    check("frl_push_unexpected", int'(frl_push_preg[k]), -1);
                end else begin
                    p = exp_frl.pop_front();
                    check("frl_push", int'(frl_push_preg[k]), p);
                end
            end
        end
        if (frl_clear) begin
            clear_count++;
            clear_cyc = cyc;
        end
        if (recovery_done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic run_case(input vec_t v);
        int t;
        int waited;
        set_rrat(v.mode);
        build_expect();
        clear_marks();
        @(posedge clk); #1;
        flush_req = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        flush_req = 1'b0;
        check("stall_rise", int'(stall_rename), 1);
        commit_busy = (v.busy > 0);
        repeat (v.busy) begin
            @(posedge clk); #1;
        end
        commit_busy = 1'b0;
        waited = 0;
        while (done_count == 0 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
            flush_req = (v.extra_at > 0 && cyc == t + v.extra_at);
        end
        flush_req = 1'b0;
        check("done_seen", int'(done_count > 0), 1);
        check("stall_fall", int'(stall_rename), 0);
        repeat (35) begin
            @(posedge clk); #1;
        end
        check("done_latency", done_cyc - t, v.lat);
        check("done_count", done_count, 1);
        check("push_count", push_count, v.pushes);
        check("rat_left", exp_rat.size(), 0);
        check("frl_left", exp_frl.size(), 0);
        check("clear_count", clear_count, 1);
        check("clear_cycle", clear_cyc - t, 2 + v.busy);
        check("first_write_cycle", first_wr_cyc, clear_cyc);
        check("last_chunk_mask", int'(last_mask), 1);
`ifdef RAT_RECOVERY_STATS_EN
        rec_total++;
        check("recovery_count", int'(recovery_count), rec_total);
        check("last_recovery_cycles", int'(last_recovery_cycles), v.lat);
`endif
    endtask

    vec_t tbl[5];
    vec_t idv;

    initial begin
        int t;
        tbl[0] = '{mode: 0, busy: 0, extra_at: 0,  lat: 27, pushes: 31};
        tbl[1] = '{mode: 0, busy: 5, extra_at: 0,  lat: 32, pushes: 31};
        tbl[2] = '{mode: 1, busy: 0, extra_at: 0,  lat: 27, pushes: 32};
        tbl[3] = '{mode: 2, busy: 0, extra_at: 0,  lat: 27, pushes: 31};
        tbl[4] = '{mode: 0, busy: 0, extra_at: 15, lat: 27, pushes: 31};
        idv    = tbl[0];

        rst = 1'b1;
        flush_req = 1'b0;
        commit_busy = 1'b0;
        set_rrat(0);
        clear_marks();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", outputs_nonzero(), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_case(tbl[i]);

        // Reset during the third COPY cycle aborts the recovery cleanly.
        set_rrat(0);
        build_expect();
        clear_marks();
        @(posedge clk); #1;
        flush_req = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_copy_stall", int'(stall_rename), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_outputs_zero", outputs_nonzero(), 0);
        check("mid_reset_cycle", cyc - t, 5);
        rst = 1'b0;
        exp_rat.delete();
        exp_frl.delete();
        clear_marks();
        rec_total = 0;
        repeat (35) begin
            @(posedge clk); #1;
        end
        check("no_done_after_reset", done_count, 0);
        check("no_write_after_reset", first_wr_cyc, -1);
        run_case(idv);
        run_case(idv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
